// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : PC owner and fetch sequencer. It fetches over a req/ack
//               handshake and buffers one instruction towards decode. Branch
//               redirects are applied here. Define FETCH_PERF_CNT_EN to add
//               the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              fault
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_wait_cnt
`endif
);

   localparam logic [ADDR_W-1:0] c_four = ADDR_W'(4);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic [ADDR_W-1:0]   r_drain_addr, w_drain_addr_nxt;
   logic [DATA_W-1:0]   r_instr_out;
   logic [ADDR_W-1:0]   r_instr_pc;
   logic                r_instr_valid, w_valid_nxt;
   logic                r_fault, w_fault_nxt;
   logic                r_halt_pend, w_halt_pend_nxt;
   logic                w_capture;
   logic                w_flush;
   logic                w_redir_take;
   logic                w_misaligned;
   logic                w_in_flight;
   state_t              w_resume;

   assign w_redir_take = redirect && (r_state != ST_HALT) && !r_halt_pend;
   assign w_misaligned = (redirect_target[1:0] != 2'b00);
   assign w_in_flight  = ((r_state == ST_REQ) || (r_state == ST_DRAIN)) && !imem_ack;
   assign w_resume     = stall ? ST_IDLE : ST_REQ;

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_drain_addr_nxt = r_drain_addr;
      w_valid_nxt      = r_instr_valid;
      w_fault_nxt      = r_fault;
      w_halt_pend_nxt  = r_halt_pend;
      w_capture        = 1'b0;
      w_flush          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!stall) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack) begin
               w_capture   = 1'b1;
               w_pc_nxt    = r_pc + c_four;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = w_resume;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) w_state_nxt = r_halt_pend ? ST_HALT : w_resume;
         end
         ST_HALT: begin
            w_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // A redirect overrides the normal flow; memory cannot cancel, so a
      // request without ack is finished in DRAIN at its original address.
      if (w_redir_take) begin
         w_capture   = 1'b0;
         w_valid_nxt = 1'b0;
         w_pc_nxt    = r_pc;
         w_flush     = (r_state == ST_REQ) || ((r_state == ST_HOLD) && !instr_ready);
         if (r_state == ST_REQ) w_drain_addr_nxt = r_pc;
         if (w_misaligned) begin
            w_fault_nxt = 1'b1;
            if (w_in_flight) begin
               w_state_nxt     = ST_DRAIN;
               w_halt_pend_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_HALT;
            end
         end else begin
            w_pc_nxt = redirect_target;
            if (w_in_flight)            w_state_nxt = ST_DRAIN;
            else if (r_state == ST_REQ) w_state_nxt = ST_REQ;
            else                        w_state_nxt = w_resume;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_drain_addr  <= RESET_PC;
         r_instr_out   <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
         r_halt_pend   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_drain_addr  <= w_drain_addr_nxt;
         r_instr_valid <= w_valid_nxt;
         r_fault       <= w_fault_nxt;
         r_halt_pend   <= w_halt_pend_nxt;
         if (w_capture) begin
            r_instr_out <= imem_rdata;
            r_instr_pc  <= r_pc;
         end
      end
   end

   assign imem_req    = (r_state == ST_REQ) || (r_state == ST_DRAIN);
   assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
   assign instr_valid = r_instr_valid;
   assign instr_out   = r_instr_out;
   assign instr_pc    = r_instr_pc;
   assign pc_plus4    = r_instr_pc + c_four;
   assign fault       = r_fault;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt, r_flush_cnt, r_wait_cnt;
   logic        w_wait_evt;

   assign w_wait_evt = imem_req && !imem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= '0;
         r_flush_cnt <= '0;
         r_wait_cnt  <= '0;
      end else begin
         if (w_capture  && (r_fetch_cnt != 32'hFFFF_FFFF)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_flush    && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
         if (w_wait_evt && (r_wait_cnt  != 32'hFFFF_FFFF)) r_wait_cnt  <= r_wait_cnt  + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_flush_cnt = r_flush_cnt;
   assign perf_wait_cnt  = r_wait_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer, with a
//               variable-latency memory responder and a delivery monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr_out, instr_pc, pc_plus4;
   logic        fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
      .pc_plus4(pc_plus4), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
      .perf_wait_cnt(perf_wait_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Memory responder: acks after a per-address number of wait cycles
   int          base_wait = 0;
   int          slow_wait = 0;
   logic [31:0] slow_addr = 32'hFFFF_FFFF;
   int          rcnt = 0;
   always @(posedge clk) begin
      #2;
      if (imem_req && rst_n) begin
         if (rcnt >= ((imem_addr == slow_addr) ? slow_wait : base_wait)) begin
            imem_ack = 1'b1;
            rcnt = 0;
         end else begin
            imem_ack = 1'b0;
            rcnt++;
         end
      end else begin
         imem_ack = 1'b0;
         rcnt = 0;
      end
   end

   logic [31:0] dq_pc[$], dq_out[$], dq_p4[$], aq_addr[$];
   int          aq_cyc[$];
   int          cur_cyc = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (instr_valid && instr_ready) begin
            dq_pc.push_back(instr_pc);
            dq_out.push_back(instr_out);
            dq_p4.push_back(pc_plus4);
         end
         if (imem_req) begin
            cur_cyc++;
            if (imem_ack) begin
               aq_addr.push_back(imem_addr);
               aq_cyc.push_back(cur_cyc);
               cur_cyc = 0;
            end
         end else begin
            cur_cyc = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      dq_pc.delete(); dq_out.delete(); dq_p4.delete();
      aq_addr.delete(); aq_cyc.delete();
      cur_cyc = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 1'b1; redirect = 1'b0;
      repeat (2) step();
      clear_logs();
      rst_n = 1'b1;
   endtask

   task automatic wait_deliv(input string tag, input int n, input int budget);
      int k = 0;
      while (dq_pc.size() < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(dq_pc.size() >= n), 32'd1);
   endtask

   task automatic wait_req_at(input string tag, input logic [31:0] a, input int budget);
      int k = 0;
      while (!(imem_req && imem_addr == a) && k < budget) begin
         step();
         k++;
      end
      check(tag, 32'(imem_req && imem_addr == a), 32'd1);
   endtask

   initial begin
      int sz;
      // Test 1: reset values, then zero-wait streaming
      rst_n = 1'b0;
      #1;
      check("rst_req",    32'(imem_req), 32'd0);
      check("rst_addr",   imem_addr, 32'h0);
      check("rst_valid",  32'(instr_valid), 32'd0);
      check("rst_pc",     instr_pc, 32'h0);
      check("rst_p4",     pc_plus4, 32'h4);
      check("rst_fault",  32'(fault), 32'd0);
      do_reset();
      stall = 1'b0;
      repeat (12) step();
      stall = 1'b1;
      repeat (4) step();
      check("t1_pc0", dq_pc[0], 32'h0);
      check("t1_pc1", dq_pc[1], 32'h4);
      check("t1_pc2", dq_pc[2], 32'h8);
      check("t1_pc3", dq_pc[3], 32'hC);
      check("t1_p4_3", dq_p4[3], 32'h10);
      check("t1_out1", dq_out[1], mem_word(32'h4));

      // Test 2: three wait cycles on address 0x8
      slow_addr = 32'h8; slow_wait = 3;
      do_reset();
      stall = 1'b0;
      wait_deliv("t2_timeout", 4, 40);
      stall = 1'b1;
      repeat (4) step();
      check("t2_addr2",  aq_addr[2], 32'h8);
      check("t2_cyc2",   32'(aq_cyc[2]), 32'd4);
      check("t2_cyc1",   32'(aq_cyc[1]), 32'd1);
      check("t2_pc2",    dq_pc[2], 32'h8);
      check("t2_out2",   dq_out[2], mem_word(32'h8));
      check("t2_pc3",    dq_pc[3], 32'hC);

      // Test 3: decode back-pressure in HOLD, then a flushing redirect
      slow_addr = 32'hFFFF_FFFF;
      instr_ready = 1'b0;
      do_reset();
      stall = 1'b0;
      begin
         int k = 0;
         while (!instr_valid && k < 20) begin step(); k++; end
      end
      for (int i = 0; i < 5; i++) begin
         check("t3_valid_noreq", 32'({instr_valid, imem_req}), 32'b10);
         check("t3_pc",          instr_pc, 32'h0);
         check("t3_out",         instr_out, mem_word(32'h0));
         step();
      end
      redirect = 1'b1; redirect_target = 32'h80;
      step();
      redirect = 1'b0;
      check("t3_flush_valid", 32'(instr_valid), 32'd0);
      check("t3_redir_req",   32'(imem_req), 32'd1);
      check("t3_redir_addr",  imem_addr, 32'h80);
      instr_ready = 1'b1; stall = 1'b1;
      repeat (4) step();
      check("t3_deliv_80", dq_pc[0], 32'h80);

      // Test 4: redirect while 0x10 is outstanding
      slow_addr = 32'h10; slow_wait = 2;
      do_reset();
      stall = 1'b0;
      wait_req_at("t4_reach10", 32'h10, 40);
      redirect = 1'b1; redirect_target = 32'h40;
      step();
      redirect = 1'b0;
      check("t4_drain_req",   32'(imem_req), 32'd1);
      check("t4_drain_addr",  imem_addr, 32'h10);
      check("t4_drain_valid", 32'(instr_valid), 32'd0);
      wait_deliv("t4_timeout", 6, 40);
      stall = 1'b1;
      repeat (4) step();
      check("t4_pc4",   dq_pc[4], 32'h40);
      check("t4_out4",  dq_out[4], mem_word(32'h40));
      check("t4_ack4",  aq_addr[4], 32'h10);
      check("t4_ack5",  aq_addr[5], 32'h40);
      check("t4_fault", 32'(fault), 32'd0);

      // Test 5: misaligned redirect -> sticky fault and halt
      stall = 1'b0;
      step();
      redirect = 1'b1; redirect_target = 32'h42;
      step();
      redirect = 1'b0;
      sz = dq_pc.size();
      for (int i = 0; i < 6; i++) begin
         check("t5_halt", 32'({fault, imem_req, instr_valid}), 32'b100);
         step();
      end
      check("t5_nodeliv", 32'(dq_pc.size()), 32'(sz));
      rst_n = 1'b0;
      #1;
      check("t5_rst_fault", 32'(fault), 32'd0);
      check("t5_rst_out",   instr_out, 32'h0);
      check("t5_rst_addr",  imem_addr, 32'h0);
      slow_addr = 32'h4; slow_wait = 3;
      step();
      clear_logs();
      rst_n = 1'b1;
      wait_deliv("t5_restart_timeout", 1, 20);
      check("t5_restart_pc", dq_pc[0], 32'h0);
      // Misaligned redirect while 0x4 is outstanding: drain, then halt
      wait_req_at("t5_reach4", 32'h4, 20);
      redirect = 1'b1; redirect_target = 32'h42;
      step();
      redirect = 1'b0;
      check("t5_drain", 32'({fault, imem_req}), 32'b11);
      check("t5_drain_addr", imem_addr, 32'h4);
      repeat (4) step();
      check("t5_halted", 32'({fault, imem_req, instr_valid}), 32'b100);

      // Test 6: PC wrap at the top of the address space
      slow_addr = 32'hFFFF_FFFF;
      do_reset();
      step();
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0; stall = 1'b0;
      repeat (8) step();
      stall = 1'b1;
      repeat (4) step();
      check("t6_pc0",  dq_pc[0], 32'hFFFF_FFFC);
      check("t6_p40",  dq_p4[0], 32'h0);
      check("t6_out0", dq_out[0], mem_word(32'hFFFF_FFFC));
      check("t6_ack1", aq_addr[1], 32'h0);
      check("t6_pc1",  dq_pc[1], 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("t6_perf_fetch", perf_fetch_cnt, 32'(dq_pc.size()));
      check("t6_perf_wait",  perf_wait_cnt, 32'd0);
      check("t6_perf_flush", perf_flush_cnt, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
